// File: rtl/blink_pwm.sv
// Prescaled wrap-programmable counter with MSB blink, terminal-count pulse
// and double-buffered PWM channels loaded on every wrap or clear.
module blink_pwm #(
    parameter int WIDTH    = 22,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1,
    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                EN,
    input  logic                CLR,
    input  logic [WIDTH-1:0]    TOP,
    input  logic                WE,
    input  logic [AW-1:0]       WADDR,
    input  logic [WIDTH-1:0]    WDATA,
    output logic [WIDTH-1:0]    O,
    output logic                TC,
    output logic [CHANNELS-1:0] PWM,
    output logic                MSB
);

    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    logic [PSW-1:0]      r_ps;
    logic [WIDTH-1:0]    r_o;
    logic                r_tc;
    logic [CHANNELS-1:0] r_pwm;
    logic [WIDTH-1:0]    r_sh  [CHANNELS];
    logic [WIDTH-1:0]    r_act [CHANNELS];

    logic                w_tick;
    logic                w_wrap;
    logic [31:0]         w_waddr;
    logic [PSW-1:0]      w_ps_nxt;
    logic [WIDTH-1:0]    w_o_nxt;
    logic [CHANNELS-1:0] w_pwm_nxt;
    logic [WIDTH-1:0]    w_sh_nxt  [CHANNELS];
    logic [WIDTH-1:0]    w_act_nxt [CHANNELS];

    assign w_waddr = 32'(WADDR);

    // PWM is compared against next-state O/ACT so it moves with O
    always_comb begin
        w_tick = EN && (r_ps == PS_LAST);
        w_wrap = w_tick && (r_o >= TOP);

        w_ps_nxt = r_ps;
        if (CLR || w_tick)
            w_ps_nxt = '0;
        else if (EN)
            w_ps_nxt = r_ps + 1'b1;

        w_o_nxt = r_o;
        if (CLR || w_wrap)
            w_o_nxt = '0;
        else if (w_tick)
            w_o_nxt = r_o + 1'b1;

        w_pwm_nxt = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_sh_nxt[ch] = r_sh[ch];
            if (WE && (w_waddr == 32'(ch)))
                w_sh_nxt[ch] = WDATA;
            w_act_nxt[ch] = r_act[ch];
            if (CLR || w_wrap)
                w_act_nxt[ch] = w_sh_nxt[ch];
            w_pwm_nxt[ch] = (w_o_nxt < w_act_nxt[ch]);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_ps  <= '0;
            r_o   <= '0;
            r_tc  <= 1'b0;
            r_pwm <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_sh[ch]  <= '0;
                r_act[ch] <= '0;
            end
        end else begin
            r_ps  <= w_ps_nxt;
            r_o   <= w_o_nxt;
            r_tc  <= w_wrap && !CLR;
            r_pwm <= w_pwm_nxt;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_sh[ch]  <= w_sh_nxt[ch];
                r_act[ch] <= w_act_nxt[ch];
            end
        end
    end

    assign O   = r_o;
    assign TC  = r_tc;
    assign PWM = r_pwm;
    assign MSB = r_o[WIDTH-1];

endmodule

// File: tb/tb_blink_pwm.sv
// Directed bench for blink_pwm: one unprescaled 3-channel instance and
// one PRESCALE=3 instance sharing the same inputs.
module tb_blink_pwm;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       EN;
    logic       CLR;
    logic [3:0] TOP;
    logic       WE;
    logic [1:0] WADDR;
    logic [3:0] WDATA;

    logic [3:0] o;
    logic       tc;
    logic [2:0] pwm;
    logic       msb;
    logic [3:0] o3;
    logic       tc3;
    logic [2:0] pwm3;
    logic       msb3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    blink_pwm #(.WIDTH(4), .CHANNELS(3), .PRESCALE(1)) dut (
        .CLK(CLK), .RESETN(RESETN), .EN(EN), .CLR(CLR), .TOP(TOP),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .O(o), .TC(tc), .PWM(pwm), .MSB(msb)
    );

    blink_pwm #(.WIDTH(4), .CHANNELS(3), .PRESCALE(3)) dut3 (
        .CLK(CLK), .RESETN(RESETN), .EN(EN), .CLR(CLR), .TOP(TOP),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .O(o3), .TC(tc3), .PWM(pwm3), .MSB(msb3)
    );

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clr;
        CLR = 1'b1;
        step();
        CLR = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        WE = 1'b1; WADDR = a; WDATA = d;
        step();
        WE = 1'b0;
    endtask

    task automatic test_reset;
        RESETN = 1'b0; EN = 1'b0; CLR = 1'b0; TOP = 4'd15;
        WE = 1'b0; WADDR = '0; WDATA = '0;
        #3;
        n_cmp++;
        if ({o, tc, pwm, msb} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_state: got o=%0d tc=%b pwm=%b msb=%b want all 0",
                     o, tc, pwm, msb);
        end
        step();
        step();
        RESETN = 1'b1;
    endtask

    task automatic test_count;
        logic [3:0] eo;
        TOP = 4'd15; EN = 1'b1;
        do_clr();
        n_cmp++;
        if (o !== 4'd0 || tc !== 1'b0) begin
            n_err++;
            $display("FAIL count_clr: got o=%0d tc=%b want o=0 tc=0", o, tc);
        end
        for (int i = 1; i <= 32; i++) begin
            step();
            eo = 4'(i % 16);
            n_cmp++;
            if (o !== eo || tc !== (eo == 0) || msb !== (eo >= 8)) begin
                n_err++;
                $display("FAIL count_%0d: got o=%0d tc=%b msb=%b want o=%0d tc=%b msb=%b",
                         i, o, tc, msb, eo, eo == 0, eo >= 8);
            end
        end
    endtask

    task automatic test_pwm;
        logic [3:0] eo;
        logic [2:0] ep;
        TOP = 4'd5; EN = 1'b1;
        wr(2'd0, 4'd2);
        wr(2'd1, 4'd0);
        wr(2'd2, 4'd9);
        wr(2'd3, 4'd0);
        do_clr();
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) step();
            eo = 4'(i % 6);
            ep = {1'b1, 1'b0, eo < 4'd2};
            n_cmp++;
            if (o !== eo || pwm !== ep) begin
                n_err++;
                $display("FAIL pwm_%0d: got o=%0d pwm=%b want o=%0d pwm=%b",
                         i, o, pwm, eo, ep);
            end
        end
    endtask

    task automatic test_prescale;
        TOP = 4'd7; EN = 1'b1;
        do_clr();
        step();
        step();
        n_cmp++;
        if (o3 !== 4'd0) begin
            n_err++;
            $display("FAIL ps_hold2: got o=%0d want 0", o3);
        end
        step();
        n_cmp++;
        if (o3 !== 4'd1) begin
            n_err++;
            $display("FAIL ps_first: got o=%0d want 1", o3);
        end
        step();
        EN = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (o3 !== 4'd1) begin
            n_err++;
            $display("FAIL ps_freeze: got o=%0d want 1", o3);
        end
        EN = 1'b1;
        step();
        n_cmp++;
        if (o3 !== 4'd1) begin
            n_err++;
            $display("FAIL ps_resume1: got o=%0d want 1", o3);
        end
        step();
        n_cmp++;
        if (o3 !== 4'd2) begin
            n_err++;
            $display("FAIL ps_resume2: got o=%0d want 2", o3);
        end
    endtask

    task automatic test_duty_update;
        logic [3:0] eo;
        logic [3:0] duty;
        TOP = 4'd9; EN = 1'b1;
        wr(2'd0, 4'd2);
        do_clr();
        for (int i = 1; i <= 40; i++) begin
            if (i == 4 || i == 30) begin
                WE = 1'b1; WADDR = 2'd0;
                WDATA = (i == 4) ? 4'd4 : 4'd7;
            end
            step();
            WE = 1'b0;
            eo = 4'(i % 10);
            duty = (i < 10) ? 4'd2 : (i < 30) ? 4'd4 : 4'd7;
            n_cmp++;
            if (o !== eo || pwm[0] !== (eo < duty)) begin
                n_err++;
                $display("FAIL duty_%0d: got o=%0d pwm0=%b want o=%0d pwm0=%b",
                         i, o, pwm[0], eo, eo < duty);
            end
        end
    endtask

    task automatic test_top_change;
        logic [3:0] eo;
        TOP = 4'd15; EN = 1'b1;
        do_clr();
        for (int i = 0; i < 10; i++) step();
        n_cmp++;
        if (o !== 4'd10) begin
            n_err++;
            $display("FAIL top_pre: got o=%0d want 10", o);
        end
        TOP = 4'd3;
        step();
        n_cmp++;
        if (o !== 4'd0 || tc !== 1'b1) begin
            n_err++;
            $display("FAIL top_wrap: got o=%0d tc=%b want o=0 tc=1", o, tc);
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            eo = 4'(i % 4);
            n_cmp++;
            if (o !== eo || tc !== (eo == 0)) begin
                n_err++;
                $display("FAIL top_%0d: got o=%0d tc=%b want o=%0d tc=%b",
                         i, o, tc, eo, eo == 0);
            end
        end
    endtask

    task automatic test_async_reset;
        TOP = 4'd15; EN = 1'b1;
        wr(2'd0, 4'd9);
        wr(2'd2, 4'd9);
        do_clr();
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (o !== 4'd6 || pwm !== 3'b101) begin
            n_err++;
            $display("FAIL rst_pre: got o=%0d pwm=%b want o=6 pwm=101", o, pwm);
        end
        #2;
        RESETN = 1'b0;
        #1;
        n_cmp++;
        if ({o, tc, pwm, msb} !== 9'd0) begin
            n_err++;
            $display("FAIL rst_async: got o=%0d tc=%b pwm=%b msb=%b want all 0",
                     o, tc, pwm, msb);
        end
        step();
        RESETN = 1'b1;
        step();
        n_cmp++;
        if (o !== 4'd1 || pwm !== 3'b000) begin
            n_err++;
            $display("FAIL rst_restart: got o=%0d pwm=%b want o=1 pwm=000", o, pwm);
        end
        do_clr();
        n_cmp++;
        if (o !== 4'd0 || pwm !== 3'b000) begin
            n_err++;
            $display("FAIL rst_sh_clear: got o=%0d pwm=%b want o=0 pwm=000", o, pwm);
        end
        wr(2'd1, 4'd5);
        WE = 1'b1; WADDR = 2'd1; WDATA = 4'd3; CLR = 1'b1;
        #2;
        RESETN = 1'b0;
        #1;
        n_cmp++;
        if ({o, tc, pwm, msb} !== 9'd0) begin
            n_err++;
            $display("FAIL rst_clrwe: got o=%0d tc=%b pwm=%b msb=%b want all 0",
                     o, tc, pwm, msb);
        end
        step();
        WE = 1'b0; CLR = 1'b0;
        RESETN = 1'b1;
        do_clr();
        n_cmp++;
        if (o !== 4'd0 || pwm !== 3'b000) begin
            n_err++;
            $display("FAIL rst_clrwe_sh: got o=%0d pwm=%b want o=0 pwm=000", o, pwm);
        end
        step();
        n_cmp++;
        if (o !== 4'd1 || pwm !== 3'b000) begin
            n_err++;
            $display("FAIL rst_clrwe_run: got o=%0d pwm=%b want o=1 pwm=000", o, pwm);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_pwm();
        test_prescale();
        test_duty_update();
        test_top_change();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
